// File: rtl/spi_write_slave.sv
// SPI write-only target: oversamples CS/SCLK/SDATA on clk_i, shifts in an LSB-first address+data
// frame and emits a one-cycle write strobe (we_o) or, for a wrong bit count, an error pulse (err_o).
module spi_write_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_i,
  input  logic              sclk_i,
  input  logic              sdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              err_o
);

  localparam int N       = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(N + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]   COUNT_FULL = CNT_W'(N);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] csSync_q, sclkSync_q, sdSync_q;
  logic                   csDly_q, sclkDly_q;
  logic                   csS, sclkS, sdS;
  logic                   sclkRise, csFall, csRise;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d;
  logic [N-1:0]      shift_q, shift_d;
  logic              goodPend_q, goodPend_d;
  logic              errPend_q, errPend_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, err_q;
  logic              armed_q, armed_d;
  logic [FLUSH_W-1:0] flush_q;
  logic              flushDone;

  assign csS   = csSync_q[SYNC_STAGES-1];
  assign sclkS = sclkSync_q[SYNC_STAGES-1];
  assign sdS   = sdSync_q[SYNC_STAGES-1];

  assign sclkRise = sclkS & ~sclkDly_q;
  assign csFall   = ~csS & csDly_q;
  assign csRise   = csS & ~csDly_q;

  // A frame may only start once the chains hold real pin samples and CS has been seen high,
  // so a CS held low across reset cannot masquerade as a fresh falling edge.
  assign flushDone = (flush_q == FLUSH_DONE);
  assign armed_d   = armed_q | (flushDone & csS);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    shift_d    = shift_q;
    goodPend_d = 1'b0;
    errPend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (csFall && armed_q) begin
          state_d   = SHIFT;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      SHIFT: begin
        // CS rising wins over a coincident SCLK edge: the frame is judged on the count already held.
        if (csRise) begin
          state_d = IDLE;
          if (count_q == COUNT_FULL && !overrun_q) begin
            goodPend_d = 1'b1;
          end else if (count_q != '0) begin
            errPend_d = 1'b1;
          end
        end else if (sclkRise) begin
          if (count_q == COUNT_FULL) begin
            overrun_d = 1'b1;
          end else begin
            shift_d = {sdS, shift_q[N-1:1]};
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csSync_q   <= '1;
      sclkSync_q <= '0;
      sdSync_q   <= '0;
      csDly_q    <= 1'b1;
      sclkDly_q  <= 1'b0;
      state_q    <= IDLE;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      shift_q    <= '0;
      goodPend_q <= 1'b0;
      errPend_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      flush_q    <= '0;
    end else begin
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_i};
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
      sdSync_q   <= {sdSync_q[SYNC_STAGES-2:0], sdata_i};
      csDly_q    <= csS;
      sclkDly_q  <= sclkS;
      state_q    <= state_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      shift_q    <= shift_d;
      goodPend_q <= goodPend_d;
      errPend_q  <= errPend_d;
      we_q       <= goodPend_q;
      err_q      <= errPend_q;
      armed_q    <= armed_d;
      if (!flushDone) begin
        flush_q <= flush_q + FLUSH_W'(1);
      end
      if (goodPend_q) begin
        addr_q  <= shift_q[ADDR_W-1:0];
        wdata_q <= shift_q[N-1:ADDR_W];
      end
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_spi_write_slave.sv
// Self-checking bench for spi_write_slave: a 1 MHz LSB-first SPI master drives directed and random
// frames, and a frame-level reference model predicts strobes and held ADDR/WDATA values.
`timescale 1ns/1ps
module tb_spi_write_slave;

  localparam int SYNC = 2;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int N    = AW + DW;

  logic          clk = 1'b0;
  logic          rst, cs, sclk, sdata;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          we, err;

  int checks = 0;
  int fails  = 0;
  int weSeen = 0, errSeen = 0, bothSeen = 0;
  logic [15:0] weQ[$];
  logic [AW-1:0] modelAddr;
  logic [DW-1:0] modelData;

  spi_write_slave #(.SYNC_STAGES(SYNC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .sclk_i(sclk), .sdata_i(sdata),
    .addr_o(addr), .wdata_o(wdata), .we_o(we), .err_o(err)
  );

  always #10 clk = ~clk;

  // Monitor samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        weSeen++;
        weQ.push_back({wdata, addr});
      end
      if (err) errSeen++;
      if (we && err) bothSeen++;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame-level reference: 0 = silent, 1 = write strobe, 2 = error pulse.
  function automatic int outcome(input int nb);
    if (nb == N) return 1;
    if (nb != 0) return 2;
    return 0;
  endfunction

  task automatic csLow();
    cs = 1'b0;
    #500;
  endtask

  task automatic sendBit(input logic b);
    sdata = b;
    #500;
    sclk = 1'b1;
    #500;
    sclk = 1'b0;
  endtask

  task automatic sendFrame(input int nb, input logic [31:0] bits);
    csLow();
    for (int i = 0; i < nb; i++) sendBit(bits[i]);
    #500;
    cs = 1'b1;
    #1000;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (we !== 1'b0) begin fails++; $display("[TB] FAIL reset_we: got %b expected 0", we); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 00", addr); end
    checks++; if (wdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_wdata: got %h expected 00", wdata); end
    modelAddr = '0;
    modelData = '0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_write();
    int w0, e0;
    @(negedge clk);
    w0 = weSeen; e0 = errSeen; weQ.delete();
    sendFrame(N, {16'h0, 8'hC3, 8'h5A});
    modelAddr = 8'h5A; modelData = 8'hC3;
    checks++; if (weSeen - w0 !== 1) begin fails++; $display("[TB] FAIL single_we_count: got %0d expected 1", weSeen - w0); end
    checks++; if (errSeen - e0 !== 0) begin fails++; $display("[TB] FAIL single_err_count: got %0d expected 0", errSeen - e0); end
    checks++; if (weQ.size() == 0 || weQ[0] !== 16'hC35A) begin fails++; $display("[TB] FAIL single_strobe_data: got %h expected c35a", weQ.size() ? weQ[0] : 16'hxxxx); end
    checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL single_hold: got %h/%h expected %h/%h", addr, wdata, modelAddr, modelData); end
  endtask

  task automatic test_latency();
    logic [31:0] bits;
    bits = $urandom;
    @(negedge clk);
    csLow();
    for (int i = 0; i < N; i++) sendBit(bits[i]);
    #500;
    @(posedge clk);
    #5;
    cs = 1'b1;
    for (int i = 1; i <= SYNC + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == SYNC + 1) begin
        checks++; if (we !== 1'b0) begin fails++; $display("[TB] FAIL latency_early: got %b expected 0 at edge %0d", we, i); end
      end else if (i == SYNC + 2) begin
        checks++; if (we !== 1'b1) begin fails++; $display("[TB] FAIL latency_we: got %b expected 1 at edge %0d", we, i); end
        checks++; if (addr !== bits[7:0] || wdata !== bits[15:8]) begin fails++; $display("[TB] FAIL latency_data: got %h/%h expected %h/%h", addr, wdata, bits[7:0], bits[15:8]); end
      end else if (i == SYNC + 3) begin
        checks++; if (we !== 1'b0) begin fails++; $display("[TB] FAIL latency_width: got %b expected 0 at edge %0d", we, i); end
      end
    end
    modelAddr = bits[7:0]; modelData = bits[15:8];
    #1000;
  endtask

  task automatic test_back_to_back();
    int w0, e0;
    @(negedge clk);
    w0 = weSeen; e0 = errSeen; weQ.delete();
    sendFrame(N, {16'h0, 8'h80, 8'h01});
    sendFrame(N, {16'h0, 8'h00, 8'hFF});
    modelAddr = 8'hFF; modelData = 8'h00;
    checks++; if (weSeen - w0 !== 2) begin fails++; $display("[TB] FAIL b2b_we_count: got %0d expected 2", weSeen - w0); end
    checks++; if (errSeen - e0 !== 0) begin fails++; $display("[TB] FAIL b2b_err_count: got %0d expected 0", errSeen - e0); end
    checks++; if (weQ.size() < 2 || weQ[0] !== 16'h8001 || weQ[1] !== 16'h00FF) begin fails++; $display("[TB] FAIL b2b_order: got %0d strobes, first %h expected 8001 then 00ff", weQ.size(), weQ.size() ? weQ[0] : 16'hxxxx); end
  endtask

  task automatic test_bad_count();
    int counts[2] = '{12, 17};
    int w0, e0;
    foreach (counts[k]) begin
      @(negedge clk);
      w0 = weSeen; e0 = errSeen;
      sendFrame(counts[k], $urandom);
      checks++; if (errSeen - e0 !== 1) begin fails++; $display("[TB] FAIL bad%0d_err: got %0d expected 1", counts[k], errSeen - e0); end
      checks++; if (weSeen - w0 !== 0) begin fails++; $display("[TB] FAIL bad%0d_we: got %0d expected 0", counts[k], weSeen - w0); end
      checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL bad%0d_hold: got %h/%h expected %h/%h", counts[k], addr, wdata, modelAddr, modelData); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0, e0;
    logic [15:0] bits;
    bits = 16'hA5C3;
    @(negedge clk);
    w0 = weSeen; e0 = errSeen;
    csLow();
    for (int i = 0; i < 6; i++) sendBit(bits[i]);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    modelAddr = '0; modelData = '0;
    for (int i = 6; i < N; i++) sendBit(bits[i]);
    #500;
    cs = 1'b1;
    #1000;
    checks++; if (weSeen - w0 !== 0 || errSeen - e0 !== 0) begin fails++; $display("[TB] FAIL midreset_silent: got we %0d err %0d expected 0 0", weSeen - w0, errSeen - e0); end
    checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL midreset_cleared: got %h/%h expected 00/00", addr, wdata); end
    w0 = weSeen;
    sendFrame(N, {16'h0, 8'h44, 8'h33});
    modelAddr = 8'h33; modelData = 8'h44;
    checks++; if (weSeen - w0 !== 1 || addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL midreset_next: got %0d strobes %h/%h expected 1 strobe 33/44", weSeen - w0, addr, wdata); end
  endtask

  task automatic test_idle_lines();
    int w0, e0;
    @(negedge clk);
    w0 = weSeen; e0 = errSeen;
    cs = 1'b0;
    #2000;
    cs = 1'b1;
    #1000;
    for (int i = 0; i < 10; i++) sendBit(i[0]);
    #1000;
    checks++; if (weSeen - w0 !== 0 || errSeen - e0 !== 0) begin fails++; $display("[TB] FAIL idle_silent: got we %0d err %0d expected 0 0", weSeen - w0, errSeen - e0); end
    checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL idle_hold: got %h/%h expected %h/%h", addr, wdata, modelAddr, modelData); end
  endtask

  task automatic test_simultaneous();
    int w0, e0;
    logic [31:0] bits;
    bits = $urandom;
    @(negedge clk);
    w0 = weSeen; e0 = errSeen;
    csLow();
    for (int i = 0; i < N; i++) sendBit(bits[i]);
    sdata = bits[16];
    #500;
    sclk = 1'b1;
    cs = 1'b1;
    #500;
    sclk = 1'b0;
    #1000;
    modelAddr = bits[7:0]; modelData = bits[15:8];
    checks++; if (weSeen - w0 !== 1 || errSeen - e0 !== 0) begin fails++; $display("[TB] FAIL simul_strobe: got we %0d err %0d expected 1 0", weSeen - w0, errSeen - e0); end
    checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL simul_data: got %h/%h expected %h/%h", addr, wdata, modelAddr, modelData); end
  endtask

  task automatic test_random();
    int w0, e0, nb, exp;
    logic [31:0] bits;
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 3))
        0:       nb = N;
        1:       nb = $urandom_range(1, N - 1);
        2:       nb = $urandom_range(N + 1, N + 4);
        default: nb = ($urandom_range(0, 1) == 0) ? 0 : N;
      endcase
      bits = $urandom;
      exp = outcome(nb);
      @(negedge clk);
      w0 = weSeen; e0 = errSeen;
      sendFrame(nb, bits);
      if (exp == 1) begin
        modelAddr = bits[7:0];
        modelData = bits[15:8];
      end
      checks++; if (weSeen - w0 !== ((exp == 1) ? 1 : 0)) begin fails++; $display("[TB] FAIL rand%0d_we nb=%0d: got %0d expected %0d", t, nb, weSeen - w0, (exp == 1) ? 1 : 0); end
      checks++; if (errSeen - e0 !== ((exp == 2) ? 1 : 0)) begin fails++; $display("[TB] FAIL rand%0d_err nb=%0d: got %0d expected %0d", t, nb, errSeen - e0, (exp == 2) ? 1 : 0); end
      checks++; if (addr !== modelAddr || wdata !== modelData) begin fails++; $display("[TB] FAIL rand%0d_data nb=%0d: got %h/%h expected %h/%h", t, nb, addr, wdata, modelAddr, modelData); end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (bothSeen !== 0) begin fails++; $display("[TB] FAIL we_err_overlap: got %0d cycles expected 0", bothSeen); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_latency();
    test_back_to_back();
    test_bad_count();
    test_reset_mid_frame();
    test_idle_lines();
    test_simultaneous();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
